// File: rtl/program_sequencer.sv
// Fetch/issue controller for the 4-bit-opcode program ROM: owns the PC, registers ROM data
// and hands instructions to the datapath over valid/ready, with SNZA skip and halt/restart.
module program_sequencer #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned LAST_ADDR  = 31
) (
   input  logic                  clk,
   input  logic                  rstN,
   input  logic                  runIn,
   input  logic                  stepModeIn,
   input  logic                  stepIn,
   input  logic                  restartIn,
   output logic [ADDR_WIDTH-1:0] romAddrOut,
   input  logic [3:0]            romDataIn,
   output logic [3:0]            instrOut,
   output logic                  instrValidOut,
   input  logic                  instrReadyIn,
   input  logic                  nzIn,
   output logic [ADDR_WIDTH-1:0] pcOut,
   output logic                  haltedOut,
   output logic                  busyOut
);

   localparam int unsigned NW      = ADDR_WIDTH + 1;
   localparam logic [3:0]  OP_SNZA = 4'b1000;
   localparam logic [3:0]  OP_CLR  = 4'b0111;
   localparam logic [NW-1:0] LAST_W = NW'(LAST_ADDR);

   typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [3:0]            instr_q, instr_d;
   logic                  valid_q, valid_d;
   logic                  halted_q, halted_d;
   logic                  handshake;
   logic                  run_go;
   logic [NW-1:0]         next_pc;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q  <= IDLE;
         pc_q     <= '0;
         instr_q  <= OP_CLR;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         valid_q  <= valid_d;
         halted_q <= halted_d;
      end
   end

   // Next PC is one bit wider than the PC so a skip past the end halts instead of wrapping.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      valid_d   = valid_q;
      halted_d  = halted_q;
      handshake = valid_q & instrReadyIn;
      run_go    = runIn & ~stepModeIn;
      next_pc   = {1'b0, pc_q} + ((instr_q == OP_SNZA && nzIn) ? NW'(2) : NW'(1));

      case (state_q)
         IDLE: begin
            if (run_go || (stepModeIn && stepIn)) state_d = FETCH;
         end
         FETCH: begin
            instr_d = romDataIn;
            valid_d = 1'b1;
            state_d = ISSUE;
         end
         ISSUE: begin
            if (handshake) begin
               valid_d = 1'b0;
               if (next_pc > LAST_W) begin
                  state_d  = HALT;
                  halted_d = 1'b1;
               end else begin
                  pc_d    = next_pc[ADDR_WIDTH-1:0];
                  state_d = run_go ? FETCH : IDLE;
               end
            end
         end
         HALT: begin
            state_d = HALT;
         end
         default: state_d = IDLE;
      endcase

      // Restart overrides everything, including a same-cycle handshake's PC update.
      if (restartIn) begin
         state_d  = IDLE;
         pc_d     = '0;
         instr_d  = OP_CLR;
         valid_d  = 1'b0;
         halted_d = 1'b0;
      end
   end

   assign romAddrOut    = pc_q;
   assign pcOut         = pc_q;
   assign instrOut      = instr_q;
   assign instrValidOut = valid_q;
   assign haltedOut     = halted_q;
   assign busyOut       = (state_q == FETCH) || (state_q == ISSUE);

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: issue order, SNZA skip, backpressure, step mode,
// end-of-program halt, restart and asynchronous reset.
module tb_program_sequencer;

   logic       clk = 1'b0;
   logic       rstN;
   logic       runIn, stepModeIn, stepIn, restartIn;
   logic [7:0] romAddrOut;
   logic [3:0] romDataIn;
   logic [3:0] instrOut;
   logic       instrValidOut, instrReadyIn, nzIn;
   logic [7:0] pcOut;
   logic       haltedOut, busyOut;

   logic [3:0] rom [0:255];
   int         checks = 0;
   int         errors = 0;
   int         hs_cnt = 0;
   int         hs_addr [$];

   program_sequencer #(.ADDR_WIDTH(8), .LAST_ADDR(31)) dut (
      .clk(clk), .rstN(rstN), .runIn(runIn), .stepModeIn(stepModeIn), .stepIn(stepIn),
      .restartIn(restartIn), .romAddrOut(romAddrOut), .romDataIn(romDataIn),
      .instrOut(instrOut), .instrValidOut(instrValidOut), .instrReadyIn(instrReadyIn),
      .nzIn(nzIn), .pcOut(pcOut), .haltedOut(haltedOut), .busyOut(busyOut)
   );

   always #5 clk = ~clk;
   assign romDataIn = rom[romAddrOut];

   // Log every accepted instruction with the address it came from.
   always @(posedge clk) begin
      if (rstN && instrValidOut && instrReadyIn) begin
         hs_cnt = hs_cnt + 1;
         hs_addr.push_back(int'(pcOut));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic restart();
      restartIn = 1'b1;
      step();
      restartIn = 1'b0;
   endtask

   task automatic load_clr();
      for (int i = 0; i < 256; i++) rom[i] = 4'b0111;
   endtask

   task automatic wait_issue(input string tag, input int addr, input int budget);
      int n = 0;
      while (!(instrValidOut === 1'b1 && int'(pcOut) == addr) && n < budget) begin
         step();
         n++;
      end
      chk(tag, 32'(instrValidOut === 1'b1 && int'(pcOut) == addr), 32'd1);
   endtask

   task automatic wait_halt(input int budget);
      int n = 0;
      while (haltedOut !== 1'b1 && n < budget) begin
         step();
         n++;
      end
      chk("halt_reached", 32'(haltedOut), 32'd1);
   endtask

   initial begin
      logic [3:0] exp_op [0:3];
      logic [3:0] exp_step [0:2];
      int n0;
      int cnt5;

      exp_op[0] = 4'b0000; exp_op[1] = 4'b0001; exp_op[2] = 4'b1010; exp_op[3] = 4'b0010;
      exp_step[0] = 4'b0001; exp_step[1] = 4'b0010; exp_step[2] = 4'b0100;

      rstN = 1'b0; runIn = 1'b0; stepModeIn = 1'b0; stepIn = 1'b0; restartIn = 1'b0;
      instrReadyIn = 1'b1; nzIn = 1'b0;
      load_clr();
      rom[0] = 4'b0000; rom[1] = 4'b0001; rom[2] = 4'b1010; rom[3] = 4'b0010;

      // Reset state
      repeat (3) step();
      chk("rst_pc", 32'(pcOut), 32'd0);
      chk("rst_valid", 32'(instrValidOut), 32'd0);
      chk("rst_instr", 32'(instrOut), 32'h7);
      chk("rst_halted", 32'(haltedOut), 32'd0);
      chk("rst_busy", 32'(busyOut), 32'd0);
      rstN = 1'b1;
      step();
      stepIn = 1'b1;
      step();
      stepIn = 1'b0;
      step();
      chk("idle_step_ignored", 32'(busyOut), 32'd0);

      // Continuous run: alternate-cycle issue, halt after 32 instructions
      hs_cnt = 0;
      runIn = 1'b1;
      step();
      chk("fetch_busy", 32'(busyOut), 32'd1);
      step();
      chk("first_valid", 32'(instrValidOut), 32'd1);
      chk("first_instr", 32'(instrOut), 32'(exp_op[0]));
      for (int i = 1; i < 4; i++) begin
         step();
         chk("gap_valid", 32'(instrValidOut), 32'd0);
         chk("gap_pc", 32'(pcOut), 32'(i));
         step();
         chk("run_valid", 32'(instrValidOut), 32'd1);
         chk("run_instr", 32'(instrOut), 32'(exp_op[i]));
      end
      wait_halt(100);
      chk("run_issued", 32'(hs_cnt), 32'd32);
      chk("run_halt_pc", 32'(pcOut), 32'd31);
      chk("run_halt_busy", 32'(busyOut), 32'd0);
      repeat (4) step();
      chk("halt_hold_pc", 32'(pcOut), 32'd31);
      chk("halt_hold_cnt", 32'(hs_cnt), 32'd32);
      runIn = 1'b0;
      restart();
      chk("restart_pc", 32'(pcOut), 32'd0);
      chk("restart_halted", 32'(haltedOut), 32'd0);

      // SNZA at 4 with nz=1 skips address 5
      load_clr();
      rom[4] = 4'b1000; rom[5] = 4'b0011;
      nzIn = 1'b1;
      hs_addr.delete();
      runIn = 1'b1;
      wait_issue("snz1_reach4", 4, 40);
      chk("snz1_instr", 32'(instrOut), 32'h8);
      step();
      chk("snz1_next_pc", 32'(pcOut), 32'd6);
      wait_issue("snz1_reach6", 6, 10);
      cnt5 = 0;
      foreach (hs_addr[i]) if (hs_addr[i] == 5) cnt5++;
      chk("snz1_no_addr5", 32'(cnt5), 32'd0);
      chk("snz1_issued", 32'(hs_addr.size()), 32'd5);
      runIn = 1'b0;
      restart();

      // SNZA at 4 with nz=0 falls through to 5, then backpressure at 5
      nzIn = 1'b0;
      runIn = 1'b1;
      wait_issue("snz0_reach4", 4, 40);
      step();
      chk("snz0_next_pc", 32'(pcOut), 32'd5);
      wait_issue("snz0_reach5", 5, 10);
      instrReadyIn = 1'b0;
      chk("snz0_instr5", 32'(instrOut), 32'h3);
      n0 = hs_cnt;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_valid", 32'(instrValidOut), 32'd1);
         chk("bp_instr", 32'(instrOut), 32'h3);
         chk("bp_pc", 32'(pcOut), 32'd5);
      end
      chk("bp_no_hs", 32'(hs_cnt), 32'(n0));
      instrReadyIn = 1'b1;
      runIn = 1'b0;
      step();
      chk("bp_release_valid", 32'(instrValidOut), 32'd0);
      chk("bp_release_pc", 32'(pcOut), 32'd6);
      chk("bp_one_hs", 32'(hs_cnt), 32'(n0 + 1));
      step();
      chk("bp_idle_busy", 32'(busyOut), 32'd0);
      chk("bp_no_dup", 32'(hs_cnt), 32'(n0 + 1));

      // Single-step mode: three pulses, three instructions
      restart();
      load_clr();
      rom[0] = 4'b0001; rom[1] = 4'b0010; rom[2] = 4'b0100;
      stepModeIn = 1'b1;
      runIn = 1'b1;
      n0 = hs_cnt;
      repeat (3) step();
      chk("step_wait_busy", 32'(busyOut), 32'd0);
      for (int k = 0; k < 3; k++) begin
         stepIn = 1'b1;
         step();
         stepIn = 1'b0;
         chk("step_fetch_busy", 32'(busyOut), 32'd1);
         step();
         chk("step_valid", 32'(instrValidOut), 32'd1);
         chk("step_instr", 32'(instrOut), 32'(exp_step[k]));
         chk("step_pc", 32'(pcOut), 32'(k));
         step();
         chk("step_after_busy", 32'(busyOut), 32'd0);
         repeat (7) step();
         chk("step_idle_busy", 32'(busyOut), 32'd0);
         chk("step_idle_pc", 32'(pcOut), 32'(k + 1));
      end
      chk("step_issued", 32'(hs_cnt), 32'(n0 + 3));

      // SNZA at LAST_ADDR-1 with nz=1 halts at 30
      stepModeIn = 1'b0;
      runIn = 1'b0;
      restart();
      load_clr();
      rom[30] = 4'b1000;
      nzIn = 1'b1;
      n0 = hs_cnt;
      runIn = 1'b1;
      wait_halt(200);
      chk("edge_halt_pc", 32'(pcOut), 32'd30);
      chk("edge_issued", 32'(hs_cnt), 32'(n0 + 31));
      stepModeIn = 1'b1;
      stepIn = 1'b1;
      step();
      stepIn = 1'b0;
      stepModeIn = 1'b0;
      repeat (5) step();
      chk("edge_hold_halted", 32'(haltedOut), 32'd1);
      chk("edge_hold_pc", 32'(pcOut), 32'd30);
      chk("edge_hold_busy", 32'(busyOut), 32'd0);
      chk("edge_hold_valid", 32'(instrValidOut), 32'd0);
      runIn = 1'b0;
      restart();
      chk("edge_restart_pc", 32'(pcOut), 32'd0);
      chk("edge_restart_halted", 32'(haltedOut), 32'd0);
      step();
      chk("edge_restart_idle", 32'(busyOut), 32'd0);

      // Async reset mid-ISSUE at pc=7
      load_clr();
      rom[2] = 4'b1000;
      nzIn = 1'b1;
      runIn = 1'b1;
      wait_issue("ar_reach7", 7, 40);
      instrReadyIn = 1'b0;
      step();
      #2;
      rstN = 1'b0;
      #1;
      chk("ar_pc", 32'(pcOut), 32'd0);
      chk("ar_valid", 32'(instrValidOut), 32'd0);
      chk("ar_instr", 32'(instrOut), 32'h7);
      chk("ar_busy", 32'(busyOut), 32'd0);
      @(posedge clk);
      #1;
      rstN = 1'b1;
      instrReadyIn = 1'b1;

      // Restart coincident with an SNZA handshake: no skip, PC back to 0
      wait_issue("rh_reach2", 2, 20);
      chk("rh_instr", 32'(instrOut), 32'h8);
      n0 = hs_cnt;
      restartIn = 1'b1;
      runIn = 1'b0;
      step();
      restartIn = 1'b0;
      chk("rh_pc", 32'(pcOut), 32'd0);
      chk("rh_valid", 32'(instrValidOut), 32'd0);
      chk("rh_instr_clr", 32'(instrOut), 32'h7);
      chk("rh_hs_kept", 32'(hs_cnt), 32'(n0 + 1));
      step();
      chk("rh_idle", 32'(busyOut), 32'd0);
      chk("rh_pc_hold", 32'(pcOut), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Fetch and issue controller for the 4-bit-opcode program ROM.
- Owns the program counter and drives the ROM address. Registers the combinational ROM output and issues each instruction to the datapath over a valid/ready handshake.
- Implements the SNZA skip-next-if-not-zero rule, run and single-step modes, end-of-program halt and synchronous restart.
- Sits between the program ROM and the CPU decode/execute stage.

Parameters:
- ADDR_WIDTH, 8, width of the PC and the ROM address.
- LAST_ADDR, 31, highest program address. Execution halts once the PC would move past it.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rstN  input  1  asynchronous active-low reset.
- runIn  input  1  level; enables continuous fetch when stepModeIn=0.
- stepModeIn  input  1  1 = single-step mode.
- stepIn  input  1  one-cycle pulse; releases exactly one instruction in step mode.
- restartIn  input  1  synchronous; returns the PC to 0 and the state to IDLE.
- romAddrOut  output  ADDR_WIDTH  ROM address; always equals pcOut.
- romDataIn  input  4  ROM dataOut (combinational).
- instrOut  output  4  issued opcode, registered.
- instrValidOut  output  1  issued opcode valid, registered.
- instrReadyIn  input  1  datapath accepts instrOut this cycle.
- nzIn  input  1  datapath not-zero flag. Sampled only on the handshake cycle of an SNZA (4'b1000).
- pcOut  output  ADDR_WIDTH  current PC.
- haltedOut  output  1  program finished.
- busyOut  output  1  state is FETCH or ISSUE.

Behaviour:
- Reset (rstN=0, async):
  - pc=0, state=IDLE.
  - instrOut=4'b0111 (CLR/NOP), instrValidOut=0, haltedOut=0, busyOut=0.
- States: IDLE, FETCH, ISSUE, HALT.
- IDLE:
  - To FETCH when (runIn & ~stepModeIn) or (stepModeIn & stepIn).
  - A stepIn pulse while not in step mode is ignored.
- FETCH (1 cycle):
  - romAddrOut=pc; instrOut <= romDataIn; instrValidOut <= 1; go to ISSUE.
- ISSUE:
  - instrOut and instrValidOut stay stable until instrReadyIn=1.
  - Handshake = instrValidOut & instrReadyIn.
  - On handshake, instrValidOut <= 0.
  - next = pc+1, or pc+2 if instrOut==4'b1000 and nzIn==1.
  - next is computed in ADDR_WIDTH+1 bits, so there is no wrap-around.
- After the handshake in ISSUE:
  - If next > LAST_ADDR: HALT, pc unchanged (holds the last executed address), haltedOut <= 1.
  - Otherwise pc <= next (truncated to ADDR_WIDTH), then:
    - FETCH if runIn & ~stepModeIn;
    - IDLE otherwise (step mode or runIn dropped).
- HALT: remains in HALT, ignoring runIn and stepIn, until restartIn.
- restartIn (any state, highest priority):
  - pc <= 0, state <= IDLE, instrValidOut <= 0, instrOut <= 4'b0111, haltedOut <= 0.
  - If a handshake occurs in the same cycle, the datapath keeps the instruction, but the PC update and skip are discarded.
- Latency and throughput:
  - From leaving IDLE to instrValidOut=1: 1 cycle.
  - With instrReadyIn held at 1: one instruction every 2 cycles.
  - Backpressure stalls indefinitely with no loss or duplication.
- Mode changes:
  - A stepModeIn or runIn change mid-ISSUE does not affect the pending instruction.
  - It takes effect only at the next IDLE/FETCH decision.
- SNZA targeting LAST_ADDR+1 or beyond: halt, not wrap. For example, SNZA at LAST_ADDR-1 with nzIn=1 halts.
- Only opcode 4'b1000 is a skip. All other opcodes, including undefined ones, advance by 1.
- busyOut = (state==FETCH) | (state==ISSUE), decoded combinationally from the state register.

Test Plan:
- Reset, runIn=1, ready=1, ROM 0:0000 1:0001 2:1010 3:0010 (then CLR to 31) -> opcodes 0000,0001,1010,0010 issued on alternate cycles; after 32 issues haltedOut=1 and pcOut=31.
- SNZA at addr 4 with nzIn=1 at handshake -> next fetch address 6, addr 5 never issued; repeat with nzIn=0 -> addr 5 issued.
- Hold instrReadyIn=0 for 5 cycles in ISSUE -> instrOut and instrValidOut stable, pcOut unchanged; on release exactly one handshake and pc+1.
- stepModeIn=1, three stepIn pulses spaced 10 cycles apart -> exactly three instructions issued (addrs 0,1,2), IDLE between them, busyOut low while idle.
- LAST_ADDR=31, SNZA at 30 with nzIn=1 -> HALT with pcOut=30; runIn and stepIn ignored; restartIn -> pcOut=0, haltedOut=0, IDLE.
- rstN pulsed low mid-ISSUE at pc=7 -> immediately pcOut=0, instrValidOut=0, instrOut=0111; restartIn coincident with a handshake -> pc=0, no skip applied.
